iob_dma_desc_seq: RTL and testbench

// - Descriptor sequencer that sits directly upstream of the iob_dma core and feeds its control path.
// - Buffers transfer descriptors {src, dst, length, irq flag} in a FIFO.
// - Issues one descriptor at a time as src_addr/dst_addr/length plus a 1-cycle start pulse, then waits for the DMA busy flag to fall.
// - Lets software queue a chain of copies without polling busy between them.

---
 rtl/iob_dma_desc_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_iob_dma_desc_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_dma_desc_seq.sv
// Descriptor sequencer in front of the iob_dma core.
// Queues {src, dst, length, irq} descriptors in a small FIFO and issues
// them one at a time to the DMA. Each issue is a 1-cycle start pulse with
// the addresses and length already on the outputs. The sequencer then
// waits for the core's busy flag to drop before it issues the next one.
// Optional feature macro: IOB_DMA_DESC_SEQ_IRQ_EN. When it is defined, a
// per-descriptor completion interrupt is stored and raised on irq_o.
//
// Handshake: a descriptor is accepted on a rising clock edge when
// desc_valid_i and desc_ready_o are both high. desc_ready_o comes only
// from the registered fill level, so it never depends on desc_valid_i in
// the same cycle. A flush_i in the same cycle drops the descriptor even
// though desc_ready_o reads 1.
module iob_dma_desc_seq #(
  parameter int AXI_ADDR_W = 24,
  parameter int LENGTH_W   = 24,
  parameter int DEPTH_W    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [AXI_ADDR_W-1:0] desc_src_i,
  input  logic [AXI_ADDR_W-1:0] desc_dst_i,
  input  logic [LENGTH_W-1:0]   desc_len_i,
  input  logic                  desc_irq_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic                  halt_i,
  input  logic                  flush_i,
  output logic [AXI_ADDR_W-1:0] src_addr_o,
  output logic [AXI_ADDR_W-1:0] dst_addr_o,
  output logic [LENGTH_W-1:0]   length_o,
  output logic                  start_o,
  input  logic                  dma_busy_i,
  output logic [DEPTH_W:0]      level_o,
  output logic [CNT_W-1:0]      done_cnt_o,
  output logic                  idle_o,
  output logic                  irq_o,
  input  logic                  irq_clr_i,
  output logic [1:0]            dbg_state_o
);

  localparam int                 DEPTH    = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ARM   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AXI_ADDR_W-1:0] mem_src [DEPTH];
  logic [AXI_ADDR_W-1:0] mem_dst [DEPTH];
  logic [LENGTH_W-1:0]   mem_len [DEPTH];

  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;

  logic [AXI_ADDR_W-1:0] src_q;
  logic [AXI_ADDR_W-1:0] dst_q;
  logic [LENGTH_W-1:0]   len_q;
  logic [CNT_W-1:0]      done_q;

  logic push;
  logic pop;
  logic issue_load;
  logic complete;
  logic head_zero;

  assign desc_ready_o = (level_q != LVL_FULL);
  assign push         = desc_valid_i & desc_ready_o & ~flush_i;
  assign head_zero    = (mem_len[rd_ptr_q] == '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the pop, issue and completion strobes.
  // A flush takes priority over a pop in IDLE, so nothing leaves a queue
  // that is being discarded.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    issue_load = 1'b0;
    complete   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !halt_i && !flush_i) begin
          pop = 1'b1;
          if (head_zero) begin
            // A zero-length descriptor never reaches the DMA and counts
            // as done immediately.
            complete = 1'b1;
          end else begin
            issue_load = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_ARM;
      // The core registers busy, so busy is not valid until one cycle
      // after start.
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (!dma_busy_i) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and level next state. A flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (!push && pop) level_d = level_q - LVL_ONE;
    end
  end

  // Descriptor storage. It has no reset because the level gates all reads.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_src[wr_ptr_q] <= desc_src_i;
      mem_dst[wr_ptr_q] <= desc_dst_i;
      mem_len[wr_ptr_q] <= desc_len_i;
    end
  end

  // FIFO control, issued-descriptor output registers and done counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (issue_load) begin
        src_q <= mem_src[rd_ptr_q];
        dst_q <= mem_dst[rd_ptr_q];
        len_q <= mem_len[rd_ptr_q];
      end
      if (complete) done_q <= done_q + CNT_ONE;
    end
  end

`ifdef IOB_DMA_DESC_SEQ_IRQ_EN
  logic mem_irq [DEPTH];
  logic inflight_irq_q;
  logic irq_q;
  logic irq_set;

  // The irq flag travels with its descriptor through the FIFO.
  always_ff @(posedge clk_i) begin
    if (push) mem_irq[wr_ptr_q] <= desc_irq_i;
  end

  // A completion in IDLE is always a zero-length pop, which uses the head
  // flag. A completion in WAIT uses the flag captured at issue.
  assign irq_set = complete &
                   ((state_q == S_IDLE) ? mem_irq[rd_ptr_q] : inflight_irq_q);

  // Sticky interrupt level. If set and clear arrive in the same cycle,
  // set wins.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      inflight_irq_q <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      if (issue_load) inflight_irq_q <= mem_irq[rd_ptr_q];
      if (irq_set)        irq_q <= 1'b1;
      else if (irq_clr_i) irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = desc_irq_i ^ irq_clr_i;
  assign irq_o             = 1'b0;
`endif

  assign src_addr_o  = src_q;
  assign dst_addr_o  = dst_q;
  assign length_o    = len_q;
  assign start_o     = (state_q == S_ISSUE);
  assign level_o     = level_q;
  assign done_cnt_o  = done_q;
  assign idle_o      = (state_q == S_IDLE) && (level_q == '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_dma_desc_seq.sv
// Testbench for iob_dma_desc_seq. It uses directed descriptor vectors.
// Each descriptor that should reach the DMA is queued as expected data.
// A monitor takes an entry off the queue on every start pulse and compares
// the issued addresses and length. A small DMA model holds busy high for a
// programmable number of cycles after each start.
// The done counter width is reduced to 4 bits so that the wrap is reached.
module tb_iob_dma_desc_seq;

  localparam int AW = 24;
  localparam int LW = 24;
  localparam int DW = 2;
  localparam int CW = 4;
  localparam int W  = 2*AW + LW;

`ifdef IOB_DMA_DESC_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] desc_src;
  logic [AW-1:0] desc_dst;
  logic [LW-1:0] desc_len;
  logic          desc_irq;
  logic          desc_valid;
  logic          desc_ready_o;
  logic          halt;
  logic          flush;
  logic [AW-1:0] src_addr_o;
  logic [AW-1:0] dst_addr_o;
  logic [LW-1:0] length_o;
  logic          start_o;
  logic          dma_busy;
  logic [DW:0]   level_o;
  logic [CW-1:0] done_cnt_o;
  logic          idle_o;
  logic          irq_o;
  logic          irq_clr;
  logic [1:0]    dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int cyc      = 0;
  int push_cyc = 0;
  int last_start_cyc = 0;
  bit have_prev = 0;
  int busy_cycles = 20;
  int busy_cnt    = 0;
  logic [W-1:0] exp_q[$];

  iob_dma_desc_seq #(
    .AXI_ADDR_W(AW), .LENGTH_W(LW), .DEPTH_W(DW), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .desc_src_i(desc_src), .desc_dst_i(desc_dst), .desc_len_i(desc_len),
    .desc_irq_i(desc_irq), .desc_valid_i(desc_valid), .desc_ready_o(desc_ready_o),
    .halt_i(halt), .flush_i(flush),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .length_o(length_o),
    .start_o(start_o), .dma_busy_i(dma_busy),
    .level_o(level_o), .done_cnt_o(done_cnt_o), .idle_o(idle_o),
    .irq_o(irq_o), .irq_clr_i(irq_clr), .dbg_state_o(dbg_state_o)
  );

  // Clock generation and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DMA model: busy rises on the edge that sees start and stays high for
  // busy_cycles cycles. The DMA is not reset with the sequencer.
  initial begin
    dma_busy = 1'b0;
  end
  always @(posedge clk) begin
    if (start_o) begin
      dma_busy <= 1'b1;
      busy_cnt <= busy_cycles;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      dma_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expected
  // descriptor, and consecutive starts must be at least 4 cycles apart.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      have_prev = 0;
    end else if (start_o) begin
      n_starts++;
      if (have_prev) check("issue_spacing_ge4", 64'((cyc - last_start_cyc) >= 4), 64'd1);
      have_prev      = 1;
      last_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_start: got start src=0x%0h expected no start", src_addr_o);
      end else begin
        e = exp_q.pop_front();
        check("issue_src", 64'(src_addr_o), 64'(e[W-1 -: AW]));
        check("issue_dst", 64'(dst_addr_o), 64'(e[LW+AW-1 -: AW]));
        check("issue_len", 64'(length_o),   64'(e[LW-1:0]));
      end
    end
  end

  // Offers one descriptor for one edge. exp_ready is the ready value we
  // predict. exp_issue says whether the descriptor should reach the DMA.
  task automatic push(input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [LW-1:0] l, input logic irq,
                      input logic exp_ready, input bit exp_issue);
    desc_src   = s;
    desc_dst   = d;
    desc_len   = l;
    desc_irq   = irq;
    desc_valid = 1'b1;
    push_cyc   = cyc;
    check("push_ready", 64'(desc_ready_o), 64'(exp_ready));
    if (exp_ready && exp_issue && (l != '0)) exp_q.push_back({s, d, l});
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (idle_o && !dma_busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_start();
    int n0 = n_starts;
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (n_starts != n0) begin
        ok = 1;
        break;
      end
    end
    check("start_timeout", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_state();
    check("rst_src",   64'(src_addr_o),   64'd0);
    check("rst_dst",   64'(dst_addr_o),   64'd0);
    check("rst_len",   64'(length_o),     64'd0);
    check("rst_start", 64'(start_o),      64'd0);
    check("rst_done",  64'(done_cnt_o),   64'd0);
    check("rst_level", 64'(level_o),      64'd0);
    check("rst_irq",   64'(irq_o),        64'd0);
    check("rst_ready", 64'(desc_ready_o), 64'd1);
    check("rst_idle",  64'(idle_o),       64'd1);
    check("rst_state", 64'(dbg_state_o),  64'd0);
  endtask

  // Directed test sequence.
  initial begin
    rst_n = 1'b0; desc_src = '0; desc_dst = '0; desc_len = '0; desc_irq = 1'b0;
    desc_valid = 1'b0; halt = 1'b0; flush = 1'b0; irq_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state();

    // Single copy: start appears two cycles after the push is presented.
    busy_cycles = 20;
    push(24'h000100, 24'h000800, 24'd16, 1'b0, 1'b1, 1);
    wait_idle();
    check("single_start_latency", 64'(last_start_cyc - push_cyc), 64'd2);
    check("single_done", 64'(done_cnt_o), 64'd1);
    check("single_idle", 64'(idle_o), 64'd1);
    check("single_starts", 64'(n_starts), 64'd1);

    // Full FIFO while halted: the fifth push is refused.
    busy_cycles = 3;
    halt = 1'b1;
    push(24'h000a00, 24'h001a00, 24'd1, 1'b0, 1'b1, 1);
    push(24'h000b00, 24'h001b00, 24'd2, 1'b0, 1'b1, 1);
    push(24'h000c00, 24'h001c00, 24'd3, 1'b0, 1'b1, 1);
    push(24'h000d00, 24'h001d00, 24'd4, 1'b0, 1'b1, 1);
    push(24'h000e00, 24'h001e00, 24'd5, 1'b0, 1'b0, 1);
    check("full_level", 64'(level_o), 64'd4);
    check("full_ready", 64'(desc_ready_o), 64'd0);
    check("full_held_idle", 64'(dbg_state_o), 64'd0);
    halt = 1'b0;
    wait_idle();
    check("full_done", 64'(done_cnt_o), 64'd5);
    check("full_starts", 64'(n_starts), 64'd5);

    // Zero length: only the len=8 descriptor is issued, but both count.
    push(24'h000f00, 24'h001f00, 24'd0, 1'b0, 1'b1, 1);
    push(24'h000123, 24'h000456, 24'd8, 1'b0, 1'b1, 1);
    wait_idle();
    check("zero_done", 64'(done_cnt_o), 64'd7);
    check("zero_starts", 64'(n_starts), 64'd6);

    // Flush with one descriptor in flight and two queued.
    busy_cycles = 30;
    push(24'h002000, 24'h003000, 24'd32, 1'b0, 1'b1, 1);
    push(24'h002100, 24'h003100, 24'd33, 1'b0, 1'b1, 0);
    push(24'h002200, 24'h003200, 24'd34, 1'b0, 1'b1, 0);
    check("flush_pre_level", 64'(level_o), 64'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_level", 64'(level_o), 64'd0);
    wait_idle();
    check("flush_done", 64'(done_cnt_o), 64'd8);
    repeat (10) @(posedge clk);
    #1;
    check("flush_starts", 64'(n_starts), 64'd7);

    // A push in the same cycle as a flush is dropped.
    flush = 1'b1;
    push(24'h004000, 24'h005000, 24'd4, 1'b0, 1'b1, 0);
    flush = 1'b0;
    check("flushpush_level", 64'(level_o), 64'd0);
    check("flushpush_idle", 64'(idle_o), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("flushpush_starts", 64'(n_starts), 64'd7);

    // Interrupt: set on completion; a set in the same cycle as a clear wins.
    busy_cycles = 5;
    push(24'h006000, 24'h007000, 24'd4, 1'b1, 1'b1, 1);
    wait_idle();
    check("irq_set", 64'(irq_o), 64'(IRQ_ON));
    check("irq_done", 64'(done_cnt_o), 64'd9);
    push(24'h006100, 24'h007100, 24'd0, 1'b1, 1'b1, 1);
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check("irq_set_beats_clr", 64'(irq_o), 64'(IRQ_ON));
    check("irq_zero_done", 64'(done_cnt_o), 64'd10);
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check("irq_cleared", 64'(irq_o), 64'd0);

    // Reset while in WAIT: outputs return to reset values, then a push
    // issues normally.
    busy_cycles = 30;
    push(24'h008000, 24'h009000, 24'd64, 1'b1, 1'b1, 1);
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    check("wait_state_reached", 64'(dbg_state_o), 64'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state();
    busy_cycles = 6;
    push(24'h00a000, 24'h00b000, 24'd12, 1'b0, 1'b1, 1);
    wait_idle();
    check("post_reset_done", 64'(done_cnt_o), 64'd1);

    // Done counter wrap: 15 more zero-length completions, 1+15 = 16 -> 0.
    for (int i = 0; i < 15; i++) push(24'(i), 24'(i), 24'd0, 1'b0, 1'b1, 1);
    wait_idle();
    check("done_wrap", 64'(done_cnt_o), 64'd0);
    check("total_starts", 64'(n_starts), 64'd10);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
